// File: rtl/sam_mem_responder.sv
// ---------------------------------------------------------------------------
// sam_mem_responder
//
// Single-port 16-bit memory responder with a fixed, parameterised access
// latency. The initiator raises `request` and holds it high. The responder
// keeps `wait_o` high until the transfer completes, then waits for
// `request` to drop before it accepts the next transfer.
//
// Parameters
//   ADDR_W   word-address bits, 1..14; the memory holds 2**ADDR_W 16-bit words
//   LATENCY  cycles from acceptance to completion, 1..15
//
// Ports
//   clk          input   single clock, rising edge
//   rst_n        input   synchronous active-low reset
//   address_bus  input   byte address; the word index is address_bus[ADDR_W:1]
//   request      input   transfer request, held high for the whole transfer
//   rw           input   1 = read, 0 = write; sampled at acceptance
//   data_in      input   write data; sampled at acceptance
//   data_out     output  read data; holds until the next read completes
//   wait_o       output  high while a transfer is in progress
//   err_o        output  misaligned-access flag
//
// Configuration macro
//   SAM_MEM_ALIGN_CHECK_EN  when defined, a request accepted with
//                           address_bus[0]=1 completes with normal timing
//                           but does not touch memory or data_out, and
//                           sets err_o. err_o clears at the next accepted
//                           request. When undefined, address_bus[0] is
//                           ignored and err_o is tied low.
// ---------------------------------------------------------------------------
module sam_mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] address_bus,
    input  logic        request,
    input  logic        rw,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        wait_o,
    output logic        err_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    count;
    logic [ADDR_W-1:0]   index;
    logic                rw_q;
    logic [15:0]         wdata;
    logic [15:0]         mem [DEPTH];

    logic                accept;
    logic                fire;
    logic                access_en;

    // A transfer is accepted in IDLE. It fires on the last BUSY cycle,
    // provided the initiator still holds the request.
    assign accept = (state == IDLE) && request;
    assign fire   = (state == BUSY) && request && (count == '0);

`ifdef SAM_MEM_ALIGN_CHECK_EN
    logic misaligned_q;
    logic err_q;

    // A misaligned transfer still completes on time, but it never reaches
    // memory or data_out.
    assign access_en = fire && !misaligned_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misaligned_q <= 1'b0;
            err_q        <= 1'b0;
        end else if (accept) begin
            misaligned_q <= address_bus[0];
            err_q        <= 1'b0;
        end else if (fire && misaligned_q) begin
            err_q        <= 1'b1;
        end
    end

    assign err_o = err_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^address_bus[15:ADDR_W+1];
`else
    assign access_en = fire;
    assign err_o     = 1'b0;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{address_bus[15:ADDR_W+1], address_bus[0]};
`endif

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples values from before the edge, regardless of the
    // order in which the blocks are evaluated.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    // NOTE: state_next is given a default before the case statement, so no
    // path can leave it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (request) state_next = BUSY;
            BUSY: begin
                if (!request)          state_next = IDLE;  // abort
                else if (count == '0)  state_next = DONE;
            end
            DONE: if (!request) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------
    // wait_o is combinational on request, so it rises in the same cycle
    // that the initiator raises request, including the first cycle after
    // reset.
    always_comb begin
        wait_o = request && (state != DONE);
    end

    // ---------------------------------------------------------------------
    // Latency counter, request capture and read data
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= '0;
            data_out <= 16'h0000;
        end else begin
            if (accept) begin
                count <= CNT_W'(LATENCY - 1);
                index <= address_bus[ADDR_W:1];
                rw_q  <= rw;
                wdata <= data_in;
            end else if ((state == BUSY) && (count != '0)) begin
                count <= count - 1'b1;
            end

            if (access_en && rw_q) begin
                data_out <= mem[index];
            end
        end
    end

    // NOTE: the memory array has no reset. Its contents survive rst_n, and
    // leaving it unreset lets it map onto RAM. Qualifying the write with
    // rst_n keeps a reset on the completion edge from committing a write.
    always_ff @(posedge clk) begin
        if (rst_n && access_en && !rw_q) begin
            mem[index] <= wdata;
        end
    end

endmodule
